// File: rtl/floo_link_chan_mux.sv
// floo_link_chan_mux: NumChan logical channels share one registered link beat per cycle,
// arbitrated by weighted round-robin among channels that are valid and hold a receiver credit.
module floo_link_chan_mux #(
    parameter int unsigned NumChan     = 3,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned CreditDepth = 4,
    parameter int unsigned WeightWidth = 4,
    parameter logic [NumChan-1:0][WeightWidth-1:0] ChanWeight = {NumChan{WeightWidth'(1)}},
    localparam int unsigned ChanW = (NumChan > 1) ? $clog2(NumChan) : 1,
    localparam int unsigned CntW  = $clog2(CreditDepth + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumChan-1:0]                valid_i,
    output logic [NumChan-1:0]                ready_o,
    input  logic [NumChan-1:0][DataWidth-1:0] data_i,
    output logic                              link_valid_o,
    output logic [ChanW-1:0]                  link_chan_o,
    output logic [DataWidth-1:0]              link_data_o,
    input  logic [NumChan-1:0]                credit_i,
    output logic                              credit_err_o
);

    localparam int unsigned IdxW = ChanW + 1;

    logic [NumChan-1:0]           elig_s;
    logic                         gnt_valid_s;
    logic [ChanW-1:0]             gnt_idx_s;
    logic [IdxW-1:0]              idx_s;
    logic [NumChan-1:0]           hs_s;
    logic                         handshake_s;

    logic [ChanW-1:0]             cur_q, cur_d;
    logic [WeightWidth-1:0]       cnt_q, cnt_d;
    logic [NumChan-1:0][CntW-1:0] credit_q, credit_d;
    logic                         credit_err_q, credit_err_d;
    logic                         link_valid_q;
    logic [ChanW-1:0]             link_chan_q;
    logic [DataWidth-1:0]         link_data_q;

    // A channel may compete only when it has a flit and a free receiver slot.
    always_comb begin
        elig_s = '0;
        for (int c = 0; c < NumChan; c++) begin
            elig_s[c] = valid_i[c] && (credit_q[c] != CntW'(0));
        end
    end

    // Turn holder keeps the link until its weight is used up; otherwise search onward, holder last.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = cur_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        idx_s       = '0;
        if (elig_s[cur_q] && (cnt_q < ChanWeight[cur_q])) begin
            gnt_valid_s = 1'b1;
            cnt_d       = cnt_q + WeightWidth'(1);
        end else begin
            for (int k = 1; k <= NumChan; k++) begin
                idx_s = IdxW'(cur_q) + IdxW'(k);
                if (idx_s >= IdxW'(NumChan)) begin
                    idx_s = idx_s - IdxW'(NumChan);
                end else begin
                    idx_s = idx_s;
                end
                if (!gnt_valid_s && elig_s[idx_s[ChanW-1:0]]) begin
                    gnt_valid_s = 1'b1;
                    gnt_idx_s   = idx_s[ChanW-1:0];
                    cur_d       = idx_s[ChanW-1:0];
                    cnt_d       = WeightWidth'(1);
                end else begin
                    gnt_valid_s = gnt_valid_s;
                end
            end
        end
    end

    // Accept is one-hot on the granted channel and suppressed while in reset.
    always_comb begin
        ready_o = '0;
        if (!rst_i && gnt_valid_s) begin
            ready_o[gnt_idx_s] = 1'b1;
        end else begin
            ready_o = '0;
        end
    end

    assign hs_s        = valid_i & ready_o;
    assign handshake_s = |hs_s;

    // Grant spends a credit, a returned credit refunds one; a refund onto a full counter is an error.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        for (int c = 0; c < NumChan; c++) begin
            if (hs_s[c] && !credit_i[c]) begin
                credit_d[c] = credit_q[c] - CntW'(1);
            end else if (!hs_s[c] && credit_i[c]) begin
                if (credit_q[c] == CntW'(CreditDepth)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[c] = credit_q[c] + CntW'(1);
                end
            end else begin
                credit_d[c] = credit_q[c];
            end
        end
    end

    // Arbiter turn state and credit bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q        <= '0;
            cnt_q        <= '0;
            credit_q     <= {NumChan{CntW'(CreditDepth)}};
            credit_err_q <= 1'b0;
        end else begin
            cur_q        <= handshake_s ? cur_d : cur_q;
            cnt_q        <= handshake_s ? cnt_d : cnt_q;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Link beat register; channel and data hold between beats.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            link_valid_q <= 1'b0;
            link_chan_q  <= '0;
            link_data_q  <= '0;
        end else if (handshake_s) begin
            link_valid_q <= 1'b1;
            link_chan_q  <= gnt_idx_s;
            link_data_q  <= data_i[gnt_idx_s];
        end else begin
            link_valid_q <= 1'b0;
            link_chan_q  <= link_chan_q;
            link_data_q  <= link_data_q;
        end
    end

    assign link_valid_o = link_valid_q;
    assign link_chan_o  = link_chan_q;
    assign link_data_o  = link_data_q;
    assign credit_err_o = credit_err_q;

    floo_link_chan_mux_chk #(
        .NumChan     (NumChan),
        .DataWidth   (DataWidth),
        .CreditDepth (CreditDepth),
        .WeightWidth (WeightWidth),
        .ChanWeight  (ChanWeight)
    ) i_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_i (ready_o),
        .data_i  (data_i)
    );

endmodule

// Parameter legality and source-side protocol properties for floo_link_chan_mux.
module floo_link_chan_mux_chk #(
    parameter int unsigned NumChan     = 3,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned CreditDepth = 4,
    parameter int unsigned WeightWidth = 4,
    parameter logic [NumChan-1:0][WeightWidth-1:0] ChanWeight = {NumChan{WeightWidth'(1)}}
) (
    input logic                              clk_i,
    input logic                              rst_i,
    input logic [NumChan-1:0]                valid_i,
    input logic [NumChan-1:0]                ready_i,
    input logic [NumChan-1:0][DataWidth-1:0] data_i
);

    if (NumChan < 1) begin : g_num_chan_bad
        $error("floo_link_chan_mux: NumChan must be at least 1");
    end
    if (CreditDepth < 1) begin : g_credit_depth_bad
        $error("floo_link_chan_mux: CreditDepth must be at least 1");
    end

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        if (ChanWeight[c] == WeightWidth'(0)) begin : g_weight_bad
            $error("floo_link_chan_mux: every ChanWeight entry must be non-zero");
        end
        // A waiting flit must stay offered, unchanged, until accepted.
        a_src_hold: assert property (@(posedge clk_i) disable iff (rst_i)
            (valid_i[c] && !ready_i[c]) |=> (valid_i[c] && $stable(data_i[c])));
    end

    a_ready_onehot: assert property (@(posedge clk_i) $onehot0(ready_i));
    a_ready_in_rst: assert property (@(posedge clk_i) rst_i |-> (ready_i == '0));

endmodule

// File: tb/tb_floo_link_chan_mux.sv
// Bench for floo_link_chan_mux: directed scenarios plus random traffic, with a queue-based
// reference model of weighted round-robin and credits; a monitor checks every link cycle.
module tb_floo_link_chan_mux;

    localparam int NC = 3;
    localparam int DW = 64;
    localparam int CD = 4;
    localparam int WW = 4;
    localparam logic [NC-1:0][WW-1:0] WGT = {4'd1, 4'd2, 4'd1};

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NC-1:0]        valid_i;
    logic [NC-1:0]        ready_o;
    logic [NC-1:0][DW-1:0] data_i;
    logic                 link_valid_o;
    logic [1:0]           link_chan_o;
    logic [DW-1:0]        link_data_o;
    logic [NC-1:0]        credit_i;
    logic                 credit_err_o;

    floo_link_chan_mux #(
        .NumChan(NC), .DataWidth(DW), .CreditDepth(CD), .WeightWidth(WW), .ChanWeight(WGT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .link_valid_o(link_valid_o), .link_chan_o(link_chan_o), .link_data_o(link_data_o),
        .credit_i(credit_i), .credit_err_o(credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            chan;
        logic [DW-1:0] data;
    } beat_t;

    int            errors = 0;
    int            checks = 0;
    beat_t         exp_q[$];
    int            m_cred[NC];
    int            m_cur = 0;
    int            m_cnt = 0;
    bit            m_err = 1'b0;
    int            m_hchan = 0;
    logic [DW-1:0] m_hdata = '0;
    int            last_g = -1;
    bit            cap_en = 1'b0;
    int            chan_log[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: turn holder keeps link for up to WGT beats, else next eligible in ring order.
    task automatic model_step();
        int g;
        logic [NC-1:0] exp_rdy;
        g = -1;
        exp_rdy = '0;
        if (rst_i) begin
            for (int c = 0; c < NC; c++) m_cred[c] = CD;
            m_cur = 0; m_cnt = 0; m_err = 1'b0; m_hchan = 0; m_hdata = '0;
        end else begin
            if (valid_i[m_cur] && m_cred[m_cur] > 0 && m_cnt < int'(WGT[m_cur])) begin
                g = m_cur;
                m_cnt++;
            end else begin
                for (int k = 1; k <= NC; k++) begin
                    int c;
                    c = (m_cur + k) % NC;
                    if (valid_i[c] && m_cred[c] > 0) begin
                        g = c; m_cur = c; m_cnt = 1;
                        break;
                    end
                end
            end
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                exp_q.push_back('{g, data_i[g]});
                m_hchan = g;
                m_hdata = data_i[g];
            end
            for (int c = 0; c < NC; c++) begin
                if (c == g && !credit_i[c]) m_cred[c]--;
                else if (c != g && credit_i[c]) begin
                    if (m_cred[c] == CD) m_err = 1'b1;
                    else m_cred[c]++;
                end
            end
        end
        chk("ready_o", 64'(ready_o), 64'(exp_rdy));
        last_g = g;
    endtask

    task automatic step(input logic r, input logic [NC-1:0] v, input logic [NC-1:0] cr,
                        output logic [NC-1:0] rdy);
        rst_i = r; valid_i = v; credit_i = cr;
        #3;
        rdy = ready_o;
        model_step();
        @(posedge clk_i);
        #1;
        if (last_g >= 0) data_i[last_g] = {$urandom, $urandom};
    endtask

    // Monitor: pops an expected beat whenever the link shows one; otherwise outputs must hold.
    always @(posedge clk_i) begin
        beat_t b;
        #2;
        if (link_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: actual chan=%0d required no beat at %0t", link_chan_o, $time);
            end else begin
                b = exp_q.pop_front();
                chk("link_chan_o", 64'(link_chan_o), 64'(b.chan));
                chk("link_data_o", link_data_o, b.data);
                if (cap_en) chan_log.push_back(int'(link_chan_o));
            end
        end else begin
            chk("beat_missing", 64'(exp_q.size()), 64'(0));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            chk("link_chan_hold", 64'(link_chan_o), 64'(m_hchan));
            chk("link_data_hold", link_data_o, m_hdata);
        end
        chk("credit_err_o", 64'(credit_err_o), 64'(m_err));
    end

    initial begin
        logic [NC-1:0] r, rv, cr, prev;
        int n;
        int exp_seq[8] = '{0, 1, 1, 2, 0, 1, 1, 2};
        rst_i = 1'b1; valid_i = '0; credit_i = '0;
        for (int c = 0; c < NC; c++) data_i[c] = {$urandom, $urandom};
        @(posedge clk_i);
        #1;
        step(1'b1, 3'b000, 3'b000, r);
        step(1'b1, 3'b000, 3'b000, r);
        chk("rst_link_valid", 64'(link_valid_o), 64'(0));
        chk("rst_credit_err", 64'(credit_err_o), 64'(0));

        // Single beat
        data_i[0] = 64'hA5;
        step(1'b0, 3'b001, 3'b000, r);
        chk("t1_ready", 64'(r), 64'(3'b001));
        chk("t1_link_valid", 64'(link_valid_o), 64'(1));
        chk("t1_link_chan", 64'(link_chan_o), 64'(0));
        chk("t1_link_data", link_data_o, 64'hA5);
        step(1'b1, 3'b000, 3'b000, r);

        // Credit exhaustion on ch1 and single refill
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'b010, 3'b000, r);
            n += int'(r[1]);
        end
        chk("t2_grants", 64'(n), 64'(4));
        step(1'b0, 3'b010, 3'b010, r);
        chk("t2_pulse_cycle", 64'(r[1]), 64'(0));
        step(1'b0, 3'b010, 3'b000, r);
        chk("t2_after_pulse", 64'(r[1]), 64'(1));
        step(1'b0, 3'b010, 3'b000, r);
        chk("t2_one_only", 64'(r[1]), 64'(0));
        step(1'b1, 3'b000, 3'b000, r);

        // Weighted round-robin order
        cap_en = 1'b1;
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'b111, prev, r);
            prev = r;
        end
        step(1'b1, 3'b000, 3'b000, r);
        cap_en = 1'b0;
        chk("t3_beats", 64'(chan_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < chan_log.size(); i++) chk("t3_seq", 64'(chan_log[i]), 64'(exp_seq[i]));

        // Simultaneous grant and credit on ch2 at counter 1
        for (int i = 0; i < 3; i++) step(1'b0, 3'b100, 3'b000, r);
        step(1'b0, 3'b100, 3'b100, r);
        chk("t4_grant_with_credit", 64'(r), 64'(3'b100));
        step(1'b0, 3'b100, 3'b000, r);
        chk("t4_grant_again", 64'(r), 64'(3'b100));
        step(1'b0, 3'b100, 3'b000, r);
        chk("t4_empty", 64'(r), 64'(3'b000));
        step(1'b1, 3'b000, 3'b000, r);

        // Overflow on idle ch0
        step(1'b0, 3'b000, 3'b001, r);
        chk("t5_err_set", 64'(credit_err_o), 64'(1));
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'b001, 3'b000, r);
            n += int'(r[0]);
        end
        chk("t5_counter_saturated", 64'(n), 64'(4));
        chk("t5_err_sticky", 64'(credit_err_o), 64'(1));
        step(1'b1, 3'b000, 3'b000, r);
        chk("t5_err_cleared", 64'(credit_err_o), 64'(0));

        // Reset mid-stream with all counters drained
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 3'b111, 3'b000, r);
            n += int'($countones(r));
        end
        chk("t6_drain", 64'(n), 64'(12));
        chk("t6_beat_inflight", 64'(link_valid_o), 64'(1));
        step(1'b1, 3'b111, 3'b000, r);
        chk("t6_ready_in_rst", 64'(r), 64'(0));
        chk("t6_beat_dropped", 64'(link_valid_o), 64'(0));
        step(1'b1, 3'b111, 3'b000, r);
        chk("t6_ready_in_rst2", 64'(r), 64'(0));
        n = 0;
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 3'b111, 3'b000, r);
            n += int'($countones(r));
        end
        chk("t6_credits_restored", 64'(n), 64'(12));
        step(1'b1, 3'b000, 3'b000, r);

        // Random traffic with a well-behaved receiver
        rv = '0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                step(1'b1, 3'b000, 3'b000, r);
                rv = '0;
            end else begin
                for (int c = 0; c < NC; c++) begin
                    if (!rv[c]) rv[c] = 1'($urandom_range(0, 1));
                    cr[c] = (m_cred[c] < CD) && ($urandom_range(0, 2) != 0);
                end
                step(1'b0, rv, cr, r);
                if (last_g >= 0 && $urandom_range(0, 1) == 0) rv[last_g] = 1'b0;
            end
        end
        step(1'b1, 3'b000, 3'b000, r);
        step(1'b0, 3'b000, 3'b000, r);
        step(1'b0, 3'b000, 3'b000, r);
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
